// File: rtl/arb_requester.sv
// Client-side requester for a 2-way round-robin arbiter that evaluates on alternate cycles.
// Optional saturating statistics counters are compiled in with `define ARB_REQ_STATS_EN.
module arb_requester #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     grant,
  output logic                     req,
  output logic                     issue_valid,
  output logic [DATA_W-1:0]        issue_data,
  output logic [$clog2(DEPTH):0]   pending
`ifdef ARB_REQ_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_grants,
  output logic [CNT_W-1:0]         stat_wait
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   occ_t;

  localparam occ_t OccFull = occ_t'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  occ_t              pending_q, pending_d;
  logic              phase_q, phase_d;
  logic              issue_valid_q, issue_valid_d;
  logic [DATA_W-1:0] issue_data_q, issue_data_d;

  logic grant_window;
  logic consume;
  logic push;

  // The arbiter only acts on phase==0 edges; a grant seen then closes the window.
  always_comb begin
    grant_window = !phase_q && grant;
    consume      = grant_window && (pending_q != '0);
    in_ready     = (pending_q != OccFull);
    push         = in_valid && in_ready;
    // Discount the entry leaving at this edge so the arbiter never grants an empty FIFO.
    req          = (pending_q - occ_t'(consume)) != '0;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    phase_d       = ~phase_q;
    wr_ptr_d      = wr_ptr_q + ptr_t'(push);
    rd_ptr_d      = rd_ptr_q + ptr_t'(consume);
    pending_d     = pending_q + occ_t'(push) - occ_t'(consume);
    issue_valid_d = consume;
    issue_data_d  = issue_data_q;
    if (consume) begin
      issue_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pending_q     <= '0;
      phase_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_data_q  <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pending_q     <= pending_d;
      phase_q       <= phase_d;
      issue_valid_q <= issue_valid_d;
      issue_data_q  <= issue_data_d;
    end
  end

  assign pending     = pending_q;
  assign issue_valid = issue_valid_q;
  assign issue_data  = issue_data_q;

`ifdef ARB_REQ_STATS_EN
  logic [CNT_W-1:0] stat_grants_q, stat_grants_d;
  logic [CNT_W-1:0] stat_wait_q, stat_wait_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_wait_d   = stat_wait_q;
    if (consume && !(&stat_grants_q)) begin
      stat_grants_d = stat_grants_q + 1'b1;
    end
    if (req && !grant_window && !(&stat_wait_q)) begin
      stat_wait_d = stat_wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_wait_q   <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_wait_q   <= stat_wait_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: vector table for single/full/spurious/simultaneous cases plus
// hand-written round-robin arbiter and mid-window reset sequences; issue data via scoreboard.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       grant;
  logic       req;
  logic       issue_valid;
  logic [7:0] issue_data;
  logic [2:0] pending;
`ifdef ARB_REQ_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_wait;
`endif

  always #5 clk = ~clk;

  arb_requester #(
    .DATA_W (8),
    .DEPTH  (4),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .grant       (grant),
    .req         (req),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .pending     (pending)
`ifdef ARB_REQ_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_wait   (stat_wait)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       g;
    logic       rdy;
    logic       rq;
    logic       rqc;
    logic [2:0] pend;
    logic       iv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic       ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic g, input logic rdy,
                     input logic rq, input logic rqc, input logic [2:0] pend, input logic iv);
    vec_t r;
    r.v = v; r.d = d; r.g = g; r.rdy = rdy; r.rq = rq; r.rqc = rqc; r.pend = pend; r.iv = iv;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic g);
    in_valid = v;
    in_data  = d;
    grant    = g;
    #1;
  endtask

  // Expected issue payloads enter the scoreboard when a push is expected to be accepted.
  task automatic tick(input logic acc);
    logic [7:0] exp_d;
    if (acc) sb.push_back(in_data);
    @(posedge clk);
    ph = ~ph;
    cyc++;
    #1;
    if (issue_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("issue_unexpected", {31'd0, issue_valid}, 32'd0);
      end else begin
        exp_d = sb.pop_front();
        chk("issue_data", {24'd0, issue_data}, {24'd0, exp_d});
      end
    end
  endtask

  initial begin
    logic       g;
    logic       last_us;
    logic       r;
    logic       p0;
    int         n_iss;
    int         last_c;
`ifdef ARB_REQ_STATS_EN
    logic [15:0] g0;
`endif

    reset = 1'b1; in_valid = 1'b0; in_data = '0; grant = 1'b0;
    #7;
    chk("reset pending",     {29'd0, pending}, 32'd0);
    chk("reset in_ready",    {31'd0, in_ready}, 32'd1);
    chk("reset req",         {31'd0, req}, 32'd0);
    chk("reset issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("reset issue_data",  {24'd0, issue_data}, 32'd0);
    #5;
    reset = 1'b0;
    ph = 1'b0;

    // v, d, g, in_ready, req, check_req, pending_after, issue_valid_after
    add(1, 8'hA5, 1, 1, 0, 0, 1, 0);  // single entry, grant held high
    add(0, 8'h00, 1, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 1);
    add(0, 8'h00, 1, 1, 0, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 1, 0, 0);
    add(1, 8'h01, 0, 1, 0, 1, 1, 0);  // fill to full
    add(1, 8'h02, 0, 1, 1, 1, 2, 0);
    add(1, 8'h03, 0, 1, 1, 1, 3, 0);
    add(1, 8'h04, 0, 1, 1, 1, 4, 0);
    add(1, 8'h05, 0, 0, 1, 1, 4, 0);
    add(1, 8'h05, 1, 0, 1, 1, 3, 1);
    add(1, 8'h05, 1, 1, 1, 1, 4, 0);
    add(0, 8'h00, 1, 0, 1, 1, 3, 1);
    add(0, 8'h00, 1, 1, 1, 1, 3, 0);
    add(0, 8'h00, 1, 1, 1, 1, 2, 1);
    add(0, 8'h00, 1, 1, 1, 1, 2, 0);
    add(0, 8'h00, 1, 1, 1, 1, 1, 1);
    add(0, 8'h00, 1, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);  // spurious grant
    add(0, 8'h00, 1, 1, 0, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 0);
    add(1, 8'h11, 0, 1, 0, 1, 1, 0);  // push on the consume edge
    add(1, 8'h22, 0, 1, 1, 1, 2, 0);
    add(1, 8'h7E, 1, 1, 1, 1, 2, 1);
    add(0, 8'h00, 1, 1, 1, 1, 2, 0);
    add(0, 8'h00, 1, 1, 1, 1, 1, 1);
    add(0, 8'h00, 1, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].g);
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      if (vecs[i].rqc) chk($sformatf("row%0d req", i), {31'd0, req}, {31'd0, vecs[i].rq});
      tick(vecs[i].v && vecs[i].rdy);
      chk($sformatf("row%0d pending", i), {29'd0, pending}, {29'd0, vecs[i].pend});
      chk($sformatf("row%0d issue_valid", i), {31'd0, issue_valid}, {31'd0, vecs[i].iv});
    end

    // Round-robin arbiter against a competitor that always requests.
    drive(1, 8'hA1, 0); tick(1);
    drive(1, 8'hB2, 0); tick(1);
    drive(1, 8'hC3, 0); tick(1);
    chk("arb preload pending", {29'd0, pending}, 32'd3);
`ifdef ARB_REQ_STATS_EN
    g0 = stat_grants;
`endif
    g = 1'b0; last_us = 1'b0; n_iss = 0; last_c = -1;
    for (int k = 0; k < 40 && n_iss < 3; k++) begin
      drive(0, 8'h00, g);
      r  = req;
      p0 = !ph;
      tick(0);
      if (issue_valid === 1'b1) begin
        if (n_iss > 0) chk("arb spacing", cyc - last_c, 32'd4);
        last_c = cyc;
        n_iss++;
      end
      if (p0) begin
        if (r && !last_us) begin g = 1'b1; last_us = 1'b1; end
        else begin g = 1'b0; last_us = 1'b0; end
      end
    end
    chk("arb issue count", n_iss, 32'd3);
    chk("arb final pending", {29'd0, pending}, 32'd0);
`ifdef ARB_REQ_STATS_EN
    chk("arb stat_grants delta", {16'd0, stat_grants - g0}, 32'd3);
`endif

    // Reset in the middle of a grant window with entries buffered.
    drive(1, 8'hD1, 0); tick(1);
    drive(1, 8'hD2, 0); tick(1);
    drive(1, 8'hD3, 0); tick(1);
    chk("pre-reset pending", {29'd0, pending}, 32'd3);
    drive(0, 8'h00, 1);
    reset = 1'b1;
    #1;
    chk("mid reset pending",     {29'd0, pending}, 32'd0);
    chk("mid reset req",         {31'd0, req}, 32'd0);
    chk("mid reset in_ready",    {31'd0, in_ready}, 32'd1);
    chk("mid reset issue_valid", {31'd0, issue_valid}, 32'd0);
`ifdef ARB_REQ_STATS_EN
    chk("mid reset stat_grants", {16'd0, stat_grants}, 32'd0);
    chk("mid reset stat_wait",   {16'd0, stat_wait}, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    ph = 1'b0;
    sb.delete();
    drive(0, 8'h00, 1);
    chk("post reset req", {31'd0, req}, 32'd0);
    tick(0);
    chk("post reset issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("post reset pending",     {29'd0, pending}, 32'd0);
    drive(1, 8'hE5, 1); tick(1);
    chk("post reset push pending", {29'd0, pending}, 32'd1);
    drive(0, 8'h00, 1); tick(0);
    chk("post reset issue", {31'd0, issue_valid}, 32'd1);
    drive(0, 8'h00, 0); tick(0);
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
